// File: rtl/cam_pkg.sv
// Shared camera/frame-buffer definitions used by both the capture (write) side
// and the VGA display (read) side of the frame BRAM.
package cam_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 12;
  localparam int COL_W    = 10;
  localparam int ROW_W    = 9;
  localparam int SKIP_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

  // b0 = RGB565[15:8], b1 = RGB565[7:0]; keep the top 4 bits of each channel.
  function automatic logic [PIX_W-1:0] rgb565_to_444(input logic [7:0] b0,
                                                     input logic [7:0] b1);
    return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
  endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// Registers the DVP pins once (S1) and derives frame/line edge pulses from the
// S1 values, so every downstream decision sees one consistent sample.
module dvp_sync_edge #(
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic       href_o,
  output logic [7:0] data_o,
  output logic       fs_o,
  output logic       fe_o,
  output logic       href_rise_o,
  output logic       href_fall_o
);
  import cam_pkg::*;

  logic       vsync_q, vsync_d;
  logic       vsync_prev_q, vsync_prev_d;
  logic       href_q, href_d;
  logic       href_prev_q, href_prev_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    vsync_d      = vsync_i;
    href_d       = href_i;
    data_d       = data_i;
    vsync_prev_d = vsync_q;
    href_prev_d  = href_q;
  end

  // Reset to the active-video vsync level so leaving reset never fakes a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q      <= ~VSYNC_POL;
      vsync_prev_q <= ~VSYNC_POL;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      data_q       <= '0;
    end else begin
      vsync_q      <= vsync_d;
      vsync_prev_q <= vsync_prev_d;
      href_q       <= href_d;
      href_prev_q  <= href_prev_d;
      data_q       <= data_d;
    end
  end

  assign href_o      = href_q;
  assign data_o      = data_q;
  assign fs_o        = (vsync_prev_q == VSYNC_POL) && (vsync_q != VSYNC_POL);
  assign fe_o        = (vsync_prev_q != VSYNC_POL) && (vsync_q == VSYNC_POL);
  assign href_rise_o = href_q & ~href_prev_q;
  assign href_fall_o = ~href_q & href_prev_q;

endmodule

// File: rtl/dvp2bram.sv
// Single-frame OV5640 DVP capture into the 12-bit RGB444 frame BRAM: FSM,
// byte-pair assembly and row-major address generation.
module dvp2bram #(
  parameter int H_ACTIVE    = cam_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = cam_pkg::V_ACTIVE,
  parameter int SKIP_FRAMES = 2,
  parameter bit VSYNC_POL   = 1'b1
) (
  input  logic                        PCLK,
  input  logic                        RESET,
  input  logic                        EN_CAPTURE,
  output logic                        CAPTURE_END,
  input  logic                        CAM_VSYNC,
  input  logic                        CAM_HREF,
  input  logic [7:0]                  CAM_DATA,
  output logic                        WE,
  output logic [cam_pkg::ADDR_W-1:0]  ADDR,
  output logic [cam_pkg::PIX_W-1:0]   DATA
);
  import cam_pkg::*;

  localparam logic [COL_W-1:0]  COL_LIM   = COL_W'(H_ACTIVE);
  localparam logic [ROW_W-1:0]  ROW_LIM   = ROW_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_ACTIVE);
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP_FRAMES);

  logic       href_s1, fs, fe, href_rise, href_fall;
  logic [7:0] data_s1;

  dvp_sync_edge #(.VSYNC_POL(VSYNC_POL)) u_sync (
    .clk         (PCLK),
    .rst         (RESET),
    .vsync_i     (CAM_VSYNC),
    .href_i      (CAM_HREF),
    .data_i      (CAM_DATA),
    .href_o      (href_s1),
    .data_o      (data_s1),
    .fs_o        (fs),
    .fe_o        (fe),
    .href_rise_o (href_rise),
    .href_fall_o (href_fall)
  );

  cap_state_e         state_q, state_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;
  logic               phase_q, phase_d;
  logic [7:0]         b0_q, b0_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PIX_W-1:0]   data_q, data_d;
  logic               end_q, end_d;

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    phase_d    = 1'b0;
    b0_d       = b0_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      ST_IDLE: begin
        if (EN_CAPTURE) begin
          skip_d  = SKIP_INIT;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (!EN_CAPTURE) begin
          state_d = ST_IDLE;
        end else if (fs) begin
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
          if (skip_q == '0) state_d = ST_CAPTURE;
          else              skip_d  = skip_q - 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (!EN_CAPTURE) begin
          state_d = ST_IDLE;
        end else begin
          // The first byte of a line is always b0, whatever phase was left behind.
          if (href_s1) begin
            if (phase_q && !href_rise) begin
              if (col_q < COL_LIM && row_q < ROW_LIM) begin
                we_d   = 1'b1;
                addr_d = row_base_q + ADDR_W'(col_q);
                data_d = rgb565_to_444(b0_q, data_s1);
                col_d  = col_q + 1'b1;
              end
            end else begin
              b0_d    = data_s1;
              phase_d = 1'b1;
            end
          end
          if (fe) begin
            state_d = ST_DONE;
          end else if (href_fall) begin
            col_d = '0;
            if (row_q < ROW_LIM) begin
              row_d      = row_q + 1'b1;
              row_base_d = row_base_q + ROW_STEP;
            end
          end
        end
      end
      ST_DONE: begin
        if (!EN_CAPTURE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    end_d = (state_d == ST_DONE);
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      phase_q    <= 1'b0;
      b0_q       <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      phase_q    <= phase_d;
      b0_q       <= b0_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      end_q      <= end_d;
    end
  end

  assign WE          = we_q;
  assign ADDR        = addr_q;
  assign DATA        = data_q;
  assign CAPTURE_END = end_q;

endmodule

// File: tb/tb_dvp2bram.sv
// Bench for dvp2bram: two instances (no skip / skip 2) on one shared DVP stream,
// each checked every cycle against a byte-level frame model.
module tb_dvp2bram;

  localparam int H    = 32;
  localparam int V    = 8;
  localparam int NPIX = H * V;
  localparam bit POL  = 1'b1;

  logic        PCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        EN_CAPTURE = 1'b0;
  logic        CAM_VSYNC = ~POL;
  logic        CAM_HREF = 1'b0;
  logic [7:0]  CAM_DATA = 8'h00;

  logic [1:0]        we_o, end_o;
  logic [1:0][18:0]  addr_o;
  logic [1:0][11:0]  data_o;

  dvp2bram #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(0), .VSYNC_POL(POL)) u_dut0 (
    .PCLK(PCLK), .RESET(RESET), .EN_CAPTURE(EN_CAPTURE), .CAPTURE_END(end_o[0]),
    .CAM_VSYNC(CAM_VSYNC), .CAM_HREF(CAM_HREF), .CAM_DATA(CAM_DATA),
    .WE(we_o[0]), .ADDR(addr_o[0]), .DATA(data_o[0]));

  dvp2bram #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2), .VSYNC_POL(POL)) u_dut2 (
    .PCLK(PCLK), .RESET(RESET), .EN_CAPTURE(EN_CAPTURE), .CAPTURE_END(end_o[1]),
    .CAM_VSYNC(CAM_VSYNC), .CAM_HREF(CAM_HREF), .CAM_DATA(CAM_DATA),
    .WE(we_o[1]), .ADDR(addr_o[1]), .DATA(data_o[1]));

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, inst, got, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 waiting for frame start, 2 capturing, 3 frame held.
  int          m_mode [2];
  int          m_skip [2];
  int          m_line [2];
  int          m_nb   [2];
  logic [7:0]  m_b0   [2];
  logic        e_we   [2];
  logic [18:0] e_addr [2];
  logic [11:0] e_data [2];
  logic        e_end  [2];
  logic        s_vs = ~POL, s_vs_p = ~POL, s_hr = 1'b0, s_hr_p = 1'b0;
  logic [7:0]  s_d = 8'h00;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_skip[i] = 0; m_line[i] = 0; m_nb[i] = 0; m_b0[i] = 8'h00;
      e_we[i] = 1'b0; e_addr[i] = '0; e_data[i] = '0; e_end[i] = 1'b0;
    end
    forever begin
      bit fs, fe, hf;
      @(posedge PCLK);
      fs = (s_vs_p == POL) && (s_vs != POL);
      fe = (s_vs_p != POL) && (s_vs == POL);
      hf = s_hr_p && !s_hr;
      for (int i = 0; i < 2; i++) begin
        e_we[i] = 1'b0;
        if (RESET) begin
          m_mode[i] = 0; m_skip[i] = 0; m_line[i] = 0; m_nb[i] = 0;
          e_addr[i] = '0; e_data[i] = '0;
        end else begin
          case (m_mode[i])
            0: if (EN_CAPTURE) begin m_skip[i] = (i == 0) ? 0 : 2; m_mode[i] = 1; end
            1: begin
              if (!EN_CAPTURE) m_mode[i] = 0;
              else if (fs) begin
                m_line[i] = 0; m_nb[i] = 0;
                if (m_skip[i] == 0) m_mode[i] = 2; else m_skip[i]--;
              end
            end
            2: begin
              if (!EN_CAPTURE) m_mode[i] = 0;
              else begin
                if (s_hr) begin
                  if (m_nb[i] % 2 == 0) m_b0[i] = s_d;
                  else if (m_nb[i] / 2 < H && m_line[i] < V) begin
                    int p, r, g, b;
                    p = {m_b0[i], s_d};
                    r = p / 2048; g = (p / 32) % 64; b = p % 32;
                    e_we[i]   = 1'b1;
                    e_addr[i] = 19'(m_line[i] * H + m_nb[i] / 2);
                    e_data[i] = 12'((r / 2) * 256 + (g / 4) * 16 + (b / 2));
                  end
                  m_nb[i]++;
                end else m_nb[i] = 0;
                if (fe) m_mode[i] = 3;
                else if (hf) m_line[i]++;
              end
            end
            default: if (!EN_CAPTURE) m_mode[i] = 0;
          endcase
        end
        e_end[i] = (m_mode[i] == 3);
      end
      s_vs_p = s_vs; s_vs = CAM_VSYNC;
      s_hr_p = s_hr; s_hr = CAM_HREF;
      s_d    = CAM_DATA;
    end
  end

  // Per-cycle compare plus a record of what each instance wrote.
  logic [11:0] mem [2][NPIX];
  bit          wrt [2][NPIX];
  int          wr_cnt [2];
  int          max_addr [2];
  logic [1:0]  we_prev = 2'b00;

  task automatic clr_track();
    for (int i = 0; i < 2; i++) begin
      wr_cnt[i] = 0; max_addr[i] = -1;
      for (int a = 0; a < NPIX; a++) wrt[i][a] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge PCLK); #1;
      if (chk_on) begin
        for (int i = 0; i < 2; i++) begin
          chk("we", i, 32'(we_o[i]), 32'(e_we[i]));
          chk("addr", i, 32'(addr_o[i]), 32'(e_addr[i]));
          chk("data", i, 32'(data_o[i]), 32'(e_data[i]));
          chk("capture_end", i, 32'(end_o[i]), 32'(e_end[i]));
          chk("we_spacing", i, 32'(we_o[i] & we_prev[i]), 32'd0);
          if (we_o[i] === 1'b1) begin
            wr_cnt[i]++;
            if (int'(addr_o[i]) > max_addr[i]) max_addr[i] = int'(addr_o[i]);
            if (int'(addr_o[i]) < NPIX) begin
              mem[i][addr_o[i]] = data_o[i];
              wrt[i][addr_o[i]] = 1'b1;
            end
          end
        end
      end
      we_prev = we_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic vs_pulse();
    CAM_VSYNC = POL;  tick(3);
    CAM_VSYNC = ~POL; tick(2);
  endtask

  task automatic en_cycle();
    EN_CAPTURE = 1'b0; tick(3);
    EN_CAPTURE = 1'b1; tick(2);
  endtask

  int snap = -1;

  // kind 0: alternating red/green full lines; 1: random lengths/data with a fixed
  // first pixel; 2: oversize first line, odd-length short second line.
  task automatic frame(input int nlines, input int kind, input logic [15:0] first_px,
                       input int abort_at, input int rst_at);
    int len, bc;
    logic [15:0] px;
    bc = 0;
    vs_pulse();
    for (int l = 0; l < nlines; l++) begin
      case (kind)
        0: len = 2 * H;
        1: len = (l == 0) ? 2 * H : int'($urandom_range(0, 2 * H + 9));
        default: len = (l == 0) ? 2 * (H + 5) : (l == 1) ? 11 : 2 * H;
      endcase
      for (int b = 0; b < len; b++) begin
        if (kind == 0) px = ((b / 2) % 2 == 1) ? 16'h07E0 : 16'hF800;
        else if (l == 0 && b < 2) px = first_px;
        else px = 16'($urandom);
        CAM_HREF = 1'b1;
        CAM_DATA = (b % 2 == 0) ? px[15:8] : px[7:0];
        if (bc == abort_at) EN_CAPTURE = 1'b0;
        if (bc == rst_at) begin RESET = 1'b1; EN_CAPTURE = 1'b0; end
        tick(1);
        if (bc == abort_at) snap = wr_cnt[0] + wr_cnt[1];
        if (RESET) begin
          RESET = 1'b0;
          for (int i = 0; i < 2; i++) begin
            chk("rst_we", i, 32'(we_o[i]), 32'd0);
            chk("rst_addr", i, 32'(addr_o[i]), 32'd0);
            chk("rst_data", i, 32'(data_o[i]), 32'd0);
            chk("rst_end", i, 32'(end_o[i]), 32'd0);
          end
        end
        bc++;
      end
      CAM_HREF = 1'b0;
      tick(3);
    end
  endtask

  initial begin
    int cnt;
    clr_track();
    tick(1);
    chk_on = 1'b1;
    tick(2);
    for (int i = 0; i < 2; i++) begin
      chk("reset_we", i, 32'(we_o[i]), 32'd0);
      chk("reset_addr", i, 32'(addr_o[i]), 32'd0);
      chk("reset_end", i, 32'(end_o[i]), 32'd0);
    end
    RESET = 1'b0;
    tick(4);

    // Full frame, no skip on instance 0.
    EN_CAPTURE = 1'b1; tick(2);
    clr_track();
    frame(V, 0, 16'h0, -1, -1);
    vs_pulse(); tick(2);
    cnt = 0;
    for (int a = 0; a < NPIX; a++) cnt += int'(wrt[0][a]);
    chk("full_writes", 0, 32'(wr_cnt[0]), 32'(NPIX));
    chk("full_no_gaps", 0, 32'(cnt), 32'(NPIX));
    chk("full_max_addr", 0, 32'(max_addr[0]), 32'(NPIX - 1));
    chk("full_px0", 0, 32'(mem[0][0]), 32'h0F00);
    chk("full_px1", 0, 32'(mem[0][1]), 32'h00F0);
    chk("full_pxlast", 0, 32'(mem[0][NPIX-1]), 32'h00F0);
    chk("full_end", 0, 32'(end_o[0]), 32'd1);
    chk("skip_no_write", 1, 32'(wr_cnt[1]), 32'd0);

    // Three frames: instance 0 keeps frame 1 (held in DONE), instance 1 takes frame 3.
    en_cycle(); clr_track();
    frame(V, 1, 16'h001F, -1, -1);
    frame(V, 1, 16'h07E0, -1, -1);
    frame(V, 1, 16'hF800, -1, -1);
    vs_pulse(); tick(2);
    chk("hold_px0", 0, 32'(mem[0][0]), 32'h000F);
    chk("skip_px0", 1, 32'(mem[1][0]), 32'h0F00);
    chk("hold_end", 0, 32'(end_o[0]), 32'd1);
    chk("skip_end", 1, 32'(end_o[1]), 32'd1);

    // Oversize then short odd-length line.
    en_cycle(); clr_track();
    frame(V, 2, 16'h0, -1, -1);
    vs_pulse(); tick(2);
    chk("over_writes", 0, 32'(wr_cnt[0]), 32'(H + 5 + (V - 2) * H));
    chk("over_last", 0, 32'(wrt[0][H-1]), 32'd1);
    chk("short_start", 0, 32'(wrt[0][H]), 32'd1);
    chk("short_tail", 0, 32'(wrt[0][H+5]), 32'd0);
    chk("next_row", 0, 32'(wrt[0][2*H]), 32'd1);

    // Extra lines beyond V.
    en_cycle(); clr_track();
    frame(V + 3, 0, 16'h0, -1, -1);
    vs_pulse(); tick(2);
    chk("extra_max_addr", 0, 32'(max_addr[0]), 32'(NPIX - 1));
    chk("extra_writes", 0, 32'(wr_cnt[0]), 32'(NPIX));
    chk("extra_end", 0, 32'(end_o[0]), 32'd1);

    // Abort mid-frame.
    en_cycle(); clr_track();
    frame(V, 0, 16'h0, 150, -1);
    vs_pulse(); tick(2);
    chk("abort_no_we", 0, 32'(wr_cnt[0] + wr_cnt[1] - snap), 32'd0);
    chk("abort_writes", 0, 32'(wr_cnt[0]), 32'(2 * H + 10));
    chk("abort_end", 0, 32'(end_o[0]), 32'd0);

    // Reset mid-line.
    EN_CAPTURE = 1'b1; tick(2);
    frame(V, 0, 16'h0, -1, 100);
    tick(4);

    // Randomised frames with random aborts and enable toggles.
    for (int r = 0; r < 8; r++) begin
      EN_CAPTURE = 1'b0; tick(int'($urandom_range(1, 4)));
      EN_CAPTURE = 1'b1; tick(int'($urandom_range(1, 3)));
      frame(V - 1 + int'($urandom_range(0, 2)), 1, 16'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300)) : -1, -1);
    end
    vs_pulse(); tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dvp2bram.md
# dvp2bram

Captures one frame from the OV5640 8-bit DVP port, converts each RGB565 byte pair to RGB444, and writes it into the 640x480x12 frame BRAM. Pixel 0 of the frame goes to address 0, row-major. This block is the write side of the frame buffer that the VGA display path reads. Capture is started by a level enable, and completion is reported by a level flag, matching the display-side handshake.

## Interface
Parameters:
- H_ACTIVE, 640, pixels stored per line; extra pixels in a line are dropped.
- V_ACTIVE, 480, lines stored per frame; extra lines are dropped.
- SKIP_FRAMES, 2, complete frames discarded after EN_CAPTURE rises, to let the sensor settle (range 0..15).
- VSYNC_POL, 1, level of CAM_VSYNC during vertical sync.

Ports (clock and reset first):
- PCLK  in  1  camera pixel clock; the only clock.
- RESET  in  1  synchronous reset, active-high.
- EN_CAPTURE  in  1  level request to capture one frame.
- CAPTURE_END  out  1  high while in DONE.
- CAM_VSYNC  in  1  DVP vertical sync.
- CAM_HREF  in  1  DVP line valid, active-high.
- CAM_DATA  in  8  DVP data bus.
- WE  out  1  BRAM write enable, one-cycle pulse per pixel.
- ADDR  out  19  BRAM write address.
- DATA  out  12  pixel value {R[3:0],G[3:0],B[3:0]}.

## Operation
- All CAM_* inputs are registered once (stage S1). All edge detection and pixel assembly use S1 values.
- Frame start (FS) is the deassertion edge of VSYNC: S1 changes from VSYNC_POL to !VSYNC_POL. Frame end (FE) is the assertion edge.
- State machine:
  - IDLE: EN_CAPTURE=1 loads skip_cnt=SKIP_FRAMES, then go to SYNC.
  - SYNC: on FS, if skip_cnt==0 go to CAPTURE; otherwise decrement skip_cnt and stay in SYNC.
  - CAPTURE: on FE go to DONE.
  - DONE: stay while EN_CAPTURE=1; when EN_CAPTURE=0 go to IDLE.
- EN_CAPTURE=0 in SYNC or CAPTURE aborts to IDLE. CAPTURE_END is not set on abort.
- Byte phase toggles on each S1 cycle with HREF=1 in CAPTURE, and clears whenever HREF=0.
  - Phase 0 stores byte b0.
  - Phase 1 combines b0 with the current byte b1 into a pixel.
  - A line with an odd byte count discards its trailing byte.
- Conversion: R=b0[7:4], G={b0[2:0],b1[7]}, B=b1[4:1].
- Counters:
  - col is 10 bits; row is 9 bits.
  - row_base is 19 bits and advances by H_ACTIVE, so no multiplier is needed.
  - ADDR = row_base + col.
- A pixel is written only when col<H_ACTIVE and row<V_ACTIVE. When written, col increments.
- HREF falling edge (S1): col returns to 0. If row<V_ACTIVE, row increments and row_base increases by H_ACTIVE. Rows are counted only in CAPTURE.
- FS in SYNC clears col, row, row_base and phase.
- A short line leaves the unwritten tail of that row unchanged. The next line still starts at the correct row_base.
- If FE and an HREF edge occur on the same cycle, FE wins. A pixel that completes on that cycle is still written.

## Timing
- Reset values:
  - state=IDLE, CAPTURE_END=0, WE=0, ADDR=0, DATA=0.
  - col, row, row_base, phase and skip_cnt are all 0.
- Latency:
  - b1 on the pins at edge k is in S1 after edge k.
  - WE=1 with valid ADDR and DATA after edge k+1, for exactly one PCLK cycle.
- Writes are at most one per two PCLKs. WE is never high outside CAPTURE.
- CAPTURE_END rises one cycle after the FE cycle. It falls one cycle after EN_CAPTURE=0 is sampled.
- Reset takes effect on any edge, mid-frame or mid-pixel. No write may occur in the cycle after RESET was sampled high.

## Structure
- Shared package `cam_pkg`:
  - frame constants H_ACTIVE and V_ACTIVE, shared with the display path;
  - ADDR_W=19 and PIX_W=12;
  - the capture state enum;
  - the RGB565-to-RGB444 conversion function.
- Natural sub-module: `dvp_sync_edge`, which registers the CAM_* inputs and produces FS, FE, href_rise and href_fall pulses.
- The top-level module holds the FSM, byte assembly and address counters.

## Test plan
- Full frame, SKIP_FRAMES=0:
  - stimulus: 480 lines of 1280 bytes, pixel n = RGB565 0xF800 for even n and 0x07E0 for odd n;
  - required: 307200 writes, ADDR 0..307199 with no gaps; DATA alternates 0xF00/0x0F0; CAPTURE_END=1 one cycle after FE.
- Skip frames:
  - stimulus: SKIP_FRAMES=2, three frames whose first pixel is 0x001F, 0x07E0, 0xF800;
  - required: only frame 3 is written, so ADDR 0 gets 0xF00.
- Oversize and short lines:
  - oversize stimulus: a 700-pixel line;
  - oversize required: 640 writes, last ADDR 639, next line starts at ADDR 640;
  - short stimulus: a line of 101 bytes;
  - short required: 50 writes, trailing byte dropped, next line starts at row_base+640.
- Extra lines: a frame of 500 lines gives no write with ADDR>307199, and CAPTURE_END is set at FE.
- Abort and reset:
  - EN_CAPTURE=0 at pixel 1000 returns the block to IDLE the next cycle, with no further WE and CAPTURE_END=0;
  - RESET pulsed mid-line zeroes all outputs on the next cycle.
- Handshake: with EN_CAPTURE held high in DONE, CAPTURE_END stays 1 and later frames are not written. After EN_CAPTURE drops and rises again, a new frame is captured.
